// File: rtl/pulse_stretch_if.sv
// Event/pulse signal bundle for pulse_stretch: event strobes in, stretched level and queue status out.
interface pulse_stretch_if #(
    parameter int unsigned PEND_W = 3
);
    logic              tick_in;
    logic              clr_ovf;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pend_cnt;
    logic              ovf;

    modport master (
        output tick_in,
        output clr_ovf,
        input  level_out,
        input  busy,
        input  pend_cnt,
        input  ovf
    );

    modport slave (
        input  tick_in,
        input  clr_ovf,
        output level_out,
        output busy,
        output pend_cnt,
        output ovf
    );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle ticks into ON_CYC-high / GAP_CYC-low pulses.
// Define PULSE_STRETCH_QUEUE_EN to queue ticks that arrive while busy (with saturation flag).
module pulse_stretch #(
    parameter int unsigned ON_CYC  = 4,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned PEND_W  = 3
) (
    input  logic            clk,
    input  logic            reset,
    pulse_stretch_if.slave  bus
);
    localparam int unsigned Q_W = 20;
    localparam logic [Q_W-1:0] ON_LOAD  = Q_W'(ON_CYC - 1);
    localparam logic [Q_W-1:0] GAP_LOAD = Q_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [Q_W-1:0] q_q, q_d;
    logic           level_q, level_d;
    logic           busy_q, busy_d;
    logic           final_gap;
    logic           pend_nz;

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;

    assign pend_nz = (pend_q != '0);
`else
    logic unused_clr_ovf;

    assign pend_nz        = 1'b0;
    assign unused_clr_ovf = bus.clr_ovf;
`endif

    assign final_gap = (state_q == GAP) && (q_q == '0);

    // Phase sequencing and down-counter
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tick_in) begin
                    state_d = ON;
                    q_d     = ON_LOAD;
                end
            end
            ON: begin
                if (q_q == '0) begin
                    state_d = GAP;
                    q_d     = GAP_LOAD;
                end else begin
                    q_d = q_q - Q_W'(1);
                end
            end
            GAP: begin
                if (q_q == '0) begin
                    if (pend_nz || bus.tick_in) begin
                        state_d = ON;
                        q_d     = ON_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    q_d = q_q - Q_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
            end
        endcase
        level_d = (state_d == ON);
        busy_d  = (state_d != IDLE);
    end

`ifdef PULSE_STRETCH_QUEUE_EN
    // A tick on the final gap cycle is consumed by the restart, so the queue only grows earlier.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (final_gap) begin
            if (pend_nz && !bus.tick_in) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end else if ((state_q != IDLE) && bus.tick_in) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.pend_cnt = pend_q;
    assign bus.ovf      = ovf_q;
`else
    assign bus.pend_cnt = '0;
    assign bus.ovf      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: cycle-distance reference model plus directed scenarios with literal expectations.
module tb_pulse_stretch;
    localparam int ON   = 4;
    localparam int GAP  = 3;
    localparam int PW   = 2;
    localparam int PMAX = 3;
    localparam int NS   = 64;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk;
    logic reset;
    pulse_stretch_if #(.PEND_W(PW)) bus ();

    pulse_stretch #(.ON_CYC(ON), .GAP_CYC(GAP), .PEND_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a pulse is "current" from its start cycle; level/busy follow from cycle distance.
    int cyc;
    int start;
    int m_pend;
    bit m_ovf;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            start  <= -1000;
            m_pend <= 0;
            m_ovf  <= 1'b0;
        end else begin
            int d, s, p;
            bit b, fin, setv, o;
            d = cyc - start;
            s = start;
            p = m_pend;
            o = m_ovf;
            b = (d >= 0) && (d < ON + GAP);
            fin = b && (d == ON + GAP - 1);
            setv = 1'b0;
            if (fin) begin
                if (p > 0 || bus.tick_in) begin
                    s = cyc + 1;
                    if (p > 0 && !bus.tick_in) p = p - 1;
                end
            end else if (b) begin
                if (bus.tick_in && QEN) begin
                    if (p == PMAX) setv = 1'b1;
                    else p = p + 1;
                end
            end else if (bus.tick_in) begin
                s = cyc + 1;
            end
            if (setv) o = 1'b1;
            else if (bus.clr_ovf && QEN) o = 1'b0;
            start  <= s;
            m_pend <= p;
            m_ovf  <= o;
            cyc    <= cyc + 1;
        end
    end

    bit tick_sched [NS];
    bit clr_sched  [NS];
    bit lvl_log    [NS];
    bit busy_log   [NS];
    bit ovf_log    [NS];
    int rises[$];
    int pend_max;
    int hi_cnt;
    bit prev_lvl;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rise_at(input int i);
        if (i < rises.size()) return rises[i];
        return -1;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < NS; i++) begin
            tick_sched[i] = 1'b0;
            clr_sched[i]  = 1'b0;
            lvl_log[i]    = 1'b0;
            busy_log[i]   = 1'b0;
            ovf_log[i]    = 1'b0;
        end
        rises.delete();
        pend_max = 0;
        hi_cnt   = 0;
        prev_lvl = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.tick_in = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_sched();
    endtask

    // Per-cycle comparison against the model, logging, then drive inputs for the current cycle.
    task automatic run_cycles(input int n);
        int ml, mb;
        repeat (n) begin
            @(negedge clk);
            ml = ((cyc - start) >= 0 && (cyc - start) < ON) ? 1 : 0;
            mb = ((cyc - start) >= 0 && (cyc - start) < ON + GAP) ? 1 : 0;
            check($sformatf("level c%0d", cyc), int'(bus.level_out), ml);
            check($sformatf("busy c%0d", cyc), int'(bus.busy), mb);
            check($sformatf("pend c%0d", cyc), int'(bus.pend_cnt), m_pend);
            check($sformatf("ovf c%0d", cyc), int'(bus.ovf), int'(m_ovf));
            if (cyc < NS) begin
                lvl_log[cyc]  = bus.level_out;
                busy_log[cyc] = bus.busy;
                ovf_log[cyc]  = bus.ovf;
            end
            if (bus.level_out && !prev_lvl) rises.push_back(cyc);
            if (bus.level_out) hi_cnt++;
            prev_lvl = bus.level_out;
            if (int'(bus.pend_cnt) > pend_max) pend_max = int'(bus.pend_cnt);
            bus.tick_in = (cyc < NS) ? tick_sched[cyc] : 1'b0;
            bus.clr_ovf = (cyc < NS) ? clr_sched[cyc] : 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.tick_in = 1'b0;
        bus.clr_ovf = 1'b0;
        #1;
        check("reset level", int'(bus.level_out), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset pend", int'(bus.pend_cnt), 0);
        check("reset ovf", int'(bus.ovf), 0);

        // Single tick
        do_reset();
        tick_sched[10] = 1'b1;
        run_cycles(25);
        check("single lvl10", int'(lvl_log[10]), 0);
        check("single lvl11", int'(lvl_log[11]), 1);
        check("single lvl14", int'(lvl_log[14]), 1);
        check("single lvl15", int'(lvl_log[15]), 0);
        check("single busy17", int'(busy_log[17]), 1);
        check("single busy18", int'(busy_log[18]), 0);
        check("single pulses", rises.size(), 1);
        check("single hi", hi_cnt, ON);

        // Ticks at 10, 12, 13
        do_reset();
        tick_sched[10] = 1'b1;
        tick_sched[12] = 1'b1;
        tick_sched[13] = 1'b1;
        run_cycles(35);
        check("queue pulses", rises.size(), QEN ? 3 : 1);
        check("queue rise0", rise_at(0), 11);
        check("queue rise1", rise_at(1), QEN ? 18 : -1);
        check("queue rise2", rise_at(2), QEN ? 25 : -1);
        check("queue pend_max", pend_max, QEN ? 2 : 0);
        check("queue pend_end", int'(bus.pend_cnt), 0);

        // Five ticks in a row, saturation, set-beats-clear, then clear
        do_reset();
        for (int i = 10; i <= 14; i++) tick_sched[i] = 1'b1;
        clr_sched[14] = 1'b1;
        clr_sched[40] = 1'b1;
        run_cycles(45);
        check("sat pulses", rises.size(), QEN ? 4 : 1);
        check("sat pend_max", pend_max, QEN ? PMAX : 0);
        check("sat ovf15", int'(ovf_log[15]), QEN ? 1 : 0);
        check("sat ovf39", int'(ovf_log[39]), QEN ? 1 : 0);
        check("sat ovf42", int'(ovf_log[42]), 0);
        check("sat rise3", rise_at(3), QEN ? 32 : -1);

        // Tick on the final gap cycle restarts without an idle cycle
        do_reset();
        tick_sched[10] = 1'b1;
        tick_sched[17] = 1'b1;
        run_cycles(30);
        check("fgap pulses", rises.size(), 2);
        check("fgap rise1", rise_at(1), 18);
        check("fgap busy18", int'(busy_log[18]), 1);
        check("fgap pend_max", pend_max, 0);

        // Asynchronous reset during ON cycle 2
        do_reset();
        tick_sched[10] = 1'b1;
        tick_sched[11] = 1'b1;
        run_cycles(12);
        check("mid lvl12", int'(lvl_log[12]), 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid rst level", int'(bus.level_out), 0);
        check("mid rst busy", int'(bus.busy), 0);
        check("mid rst pend", int'(bus.pend_cnt), 0);
        check("mid rst ovf", int'(bus.ovf), 0);
        do_reset();
        tick_sched[3] = 1'b1;
        run_cycles(15);
        check("post rst pulses", rises.size(), 1);
        check("post rst rise", rise_at(0), 4);
        check("post rst hi", hi_cnt, ON);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
